// File: rtl/lsu_pkg.sv
// Load/store unit shared types: access size and control state encodings,
// plus the byte-enable helper used for lane mapping.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_SIZE_BYTE = 2'b00,
    LSU_SIZE_HALF = 2'b01,
    LSU_SIZE_WORD = 2'b10,
    LSU_SIZE_BAD  = 2'b11
  } lsu_size_t;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ0,
    LSU_WAIT0,
    LSU_REQ1,
    LSU_WAIT1,
    LSU_RESP
  } lsu_state_t;

  // 7-bit enables: bits [6:4] are the lanes that spill into the next word.
  function automatic logic [6:0] lsu_be(
    input lsu_size_t  size,
    input logic [1:0] off
  );
    logic [6:0] b;
    case (size)
      LSU_SIZE_BYTE: b = 7'b0000001;
      LSU_SIZE_HALF: b = 7'b0000011;
      LSU_SIZE_WORD: b = 7'b0001111;
      default:       b = 7'b0000000;
    endcase
    return b << off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane shifter: byte enables / write data shifted into memory lanes, and
// load data merged from up to two words, masked and extended.
// Ports: size, uns, off, wdata, rdata0, rdata1 -> be, wdata_lo/hi, rdata.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_t   size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic [6:0]  be,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] rdata
);

  logic [63:0] wide;
  logic [31:0] raw;

  always_comb begin
    be       = lsu_be(size, off);
    wide     = {32'b0, wdata} << {off, 3'b000};
    wdata_lo = wide[31:0];
    wdata_hi = wide[63:32];
    // rdata1 only contributes above the first word's remaining bytes
    raw      = 32'({rdata1, rdata0} >> {off, 3'b000});
    rdata    = raw;
    unique case (size)
      LSU_SIZE_BYTE: rdata = {{24{~uns & raw[7]}}, raw[7:0]};
      LSU_SIZE_HALF: rdata = {{16{~uns & raw[15]}}, raw[15:0]};
      default:       rdata = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time onto a req/gnt/rvalid word bus.
// Datapath side: req_* in, resp_* out. Memory side: mem_* bus.
// LSU_MISALIGNED_EN: when defined, misaligned accesses are served
// (split into two bus accesses when they cross a word); else they error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t  state;
  lsu_size_t   size_q;
  logic        we_q, uns_q, split_q;
  logic [1:0]  off_q;
  logic [31:0] r0_q, wdata_hi_q;
  logic [3:0]  be_hi_q;
  logic [CW-1:0] cnt;

  logic        idle, reject, split, tmo, a_uns;
  lsu_size_t   a_size;
  logic [1:0]  a_off;
  logic [6:0]  a_be;
  logic [31:0] a_r0, a_r1, a_wlo, a_whi, a_rdata;

  assign idle        = (state == LSU_IDLE);
  assign req_ready_o = idle;

  // While idle the shifter sees the incoming request; afterwards the
  // latched fields, so loads are aligned with the access's own size/offset.
  assign a_size = idle ? lsu_size_t'(req_size_i) : size_q;
  assign a_uns  = idle ? req_unsigned_i : uns_q;
  assign a_off  = idle ? req_addr_i[1:0] : off_q;
  assign a_r0   = (state == LSU_WAIT1) ? r0_q : mem_rdata_i;
  assign a_r1   = (state == LSU_WAIT1) ? mem_rdata_i : 32'h0;

  lsu_align u_align (
    .size     (a_size),
    .uns      (a_uns),
    .off      (a_off),
    .wdata    (req_wdata_i),
    .rdata0   (a_r0),
    .rdata1   (a_r1),
    .be       (a_be),
    .wdata_lo (a_wlo),
    .wdata_hi (a_whi),
    .rdata    (a_rdata)
  );

`ifdef LSU_MISALIGNED_EN
  assign reject = (req_size_i == 2'b11);
  assign split  = |a_be[6:4];
`else
  logic mis;
  assign mis = (req_size_i == 2'b01 && req_addr_i[0])
            || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
  assign reject = (req_size_i == 2'b11) || mis;
  assign split  = 1'b0;
`endif

  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= LSU_IDLE;
      size_q       <= LSU_SIZE_BYTE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      split_q      <= 1'b0;
      off_q        <= 2'b00;
      r0_q         <= '0;
      wdata_hi_q   <= '0;
      be_hi_q      <= '0;
      cnt          <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_we_o     <= 1'b0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      unique case (state)
        LSU_IDLE: if (req_valid_i) begin
          size_q     <= lsu_size_t'(req_size_i);
          we_q       <= req_we_i;
          uns_q      <= req_unsigned_i;
          off_q      <= req_addr_i[1:0];
          split_q    <= split;
          be_hi_q    <= {1'b0, a_be[6:4]};
          wdata_hi_q <= a_whi;
          if (reject) begin
            state        <= LSU_RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_rdata_o <= '0;
          end else begin
            state       <= LSU_REQ0;
            mem_req_o   <= 1'b1;
            mem_addr_o  <= {req_addr_i[31:2], 2'b00};
            mem_we_o    <= req_we_i;
            mem_be_o    <= a_be[3:0];
            mem_wdata_o <= a_wlo;
          end
        end
        LSU_REQ0, LSU_REQ1: if (mem_gnt_i) begin
          mem_req_o <= 1'b0;
          cnt       <= '0;
          state     <= (state == LSU_REQ0) ? LSU_WAIT0 : LSU_WAIT1;
        end
        LSU_WAIT0, LSU_WAIT1: begin
          if (mem_rvalid_i) begin
            if (state == LSU_WAIT0 && split_q) begin
              r0_q        <= mem_rdata_i;
              state       <= LSU_REQ1;
              mem_req_o   <= 1'b1;
              mem_addr_o  <= mem_addr_o + 32'd4;
              mem_be_o    <= be_hi_q;
              mem_wdata_o <= wdata_hi_q;
            end else begin
              state        <= LSU_RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b0;
              resp_rdata_o <= we_q ? 32'h0 : a_rdata;
            end
          end else if (tmo) begin
            state        <= LSU_RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_rdata_o <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LSU_RESP: begin
          state        <= LSU_IDLE;
          resp_valid_o <= 1'b0;
          resp_err_o   <= 1'b0;
          resp_rdata_o <= '0;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
